// File: rtl/lane_pkg.sv
// Shared geometry defaults and width helpers for the lane block engine.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package lane_pkg;

  localparam int DEF_SPAWN_H  = 120;
  localparam int DEF_BOTTOM_H = 720;
  localparam int DEF_HIT_LO   = 600;
  localparam int DEF_HIT_HI   = 680;

  // Width of an index selecting one of n slots (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int num_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lane_slot_pick.sv
// Priority picker: returns the lowest set bit of req as an index plus a found flag.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request bit is set.
module lane_slot_pick
  import lane_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top so the lowest set bit is the last, winning assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_block_pool.sv
// Per-lane falling-block pool: spawns on beat edges, moves blocks down, judges key presses.
// Latency: one clock from any input event to slot state, pulses and counters.
// Backpressure: none; a spawn with every slot live is dropped and flagged on overflow.
module lane_block_pool
  import lane_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int H_W      = 10,
  parameter int BEAT_W   = 7,
  parameter int CNT_W    = 8,
  parameter int SPAWN_H  = DEF_SPAWN_H,
  parameter int BOTTOM_H = DEF_BOTTOM_H,
  parameter int STEP     = 1,
  parameter int HIT_LO   = DEF_HIT_LO,
  parameter int HIT_HI   = DEF_HIT_HI
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 stop_or_endgame,
  input  logic [BEAT_W-1:0]    beat_cnt,
  input  logic                 spawn_en,
  input  logic                 key_press,
  output logic [SLOTS*H_W-1:0] block_h,
  output logic [SLOTS-1:0]     block_valid,
  output logic                 hit_pulse,
  output logic                 bad_press,
  output logic                 miss_pulse,
  output logic                 overflow,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  localparam int IW = idx_w(SLOTS);
  localparam int MW = num_w(SLOTS);
  localparam int SW = CNT_W + MW;

  typedef logic [H_W-1:0] h_t;
  typedef logic [H_W:0]   hx_t;   // one extra bit so h+STEP never wraps

  localparam h_t  H_SPAWN  = h_t'(SPAWN_H);
  localparam h_t  H_FLOOR  = h_t'(BOTTOM_H);
  localparam hx_t FLOOR_X  = hx_t'(BOTTOM_H);
  localparam hx_t STEP_X   = hx_t'(STEP);
  localparam hx_t HIT_LO_X = hx_t'(HIT_LO);
  localparam hx_t HIT_HI_X = hx_t'(HIT_HI);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  h_t                h_q [SLOTS];
  h_t                h_d [SLOTS];
  logic [SLOTS-1:0]  valid_d;
  logic [SLOTS-1:0]  free_req;
  logic [SLOTS-1:0]  hit_sel;
  logic [SLOTS-1:0]  miss_vec;
  logic [BEAT_W-1:0] pre_beat;
  logic              beat_add;
  logic              spawn_req;
  logic              spawn_found;
  logic [IW-1:0]     spawn_idx;
  logic              hit_found;
  h_t                best_h;
  hx_t               h_step;
  logic [MW-1:0]     miss_num;
  logic [SW-1:0]     miss_sum;

  // A beat edge is a strict increase; a wrap back to zero does not spawn.
  assign beat_add  = beat_cnt > pre_beat;
  assign spawn_req = beat_add && spawn_en && !stop_or_endgame;
  assign free_req  = ~block_valid;

  // Spawn allocation looks at registered valid, so a slot freed this cycle waits a cycle.
  lane_slot_pick #(.N(SLOTS), .IW(IW)) u_spawn_pick (
    .req   (free_req),
    .idx   (spawn_idx),
    .found (spawn_found)
  );

  // Hit candidate: live slot in the window with the largest pre-move height, lowest index on ties.
  always_comb begin
    hit_sel   = '0;
    hit_found = 1'b0;
    best_h    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (block_valid[i] && (hx_t'(h_q[i]) >= HIT_LO_X) && (hx_t'(h_q[i]) <= HIT_HI_X) &&
          (!hit_found || (h_q[i] > best_h))) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit_found  = 1'b1;
        best_h     = h_q[i];
      end
    end
  end

  // Next slot state: hit clears first, otherwise move and retire at the floor, then spawn.
  always_comb begin
    h_d      = h_q;
    valid_d  = block_valid;
    miss_vec = '0;
    h_step   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (block_valid[i]) begin
        h_step = hx_t'(h_q[i]) + STEP_X;
        if (key_press && hit_sel[i]) begin
          valid_d[i] = 1'b0;
          h_d[i]     = H_FLOOR;
        end else if (h_step >= FLOOR_X) begin
          valid_d[i]  = 1'b0;
          h_d[i]      = H_FLOOR;
          miss_vec[i] = 1'b1;
        end else begin
          h_d[i] = h_step[H_W-1:0];
        end
      end
    end
    if (spawn_req && spawn_found) begin
      valid_d[spawn_idx] = 1'b1;
      h_d[spawn_idx]     = H_SPAWN;
    end
  end

  // Count blocks that hit the floor this cycle and form the saturating miss total.
  always_comb begin
    miss_num = '0;
    for (int i = 0; i < SLOTS; i++) begin
      miss_num = miss_num + MW'(miss_vec[i]);
    end
    miss_sum = SW'(miss_cnt) + SW'(miss_num);
  end

  // Flatten slot heights onto the renderer bus.
  always_comb begin
    block_h = '0;
    for (int i = 0; i < SLOTS; i++) begin
      block_h[i*H_W +: H_W] = h_q[i];
    end
  end

  // Slot state, beat history, registered pulses and saturating totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) h_q[i] <= H_FLOOR;
      block_valid <= '0;
      pre_beat    <= '0;
      hit_pulse   <= 1'b0;
      bad_press   <= 1'b0;
      miss_pulse  <= 1'b0;
      overflow    <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else if (restart) begin
      for (int i = 0; i < SLOTS; i++) h_q[i] <= H_FLOOR;
      block_valid <= '0;
      pre_beat    <= '0;
      hit_pulse   <= 1'b0;
      bad_press   <= 1'b0;
      miss_pulse  <= 1'b0;
      overflow    <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else if (stop_or_endgame) begin
      // Frozen, but keep tracking the beat so resuming does not see a stale edge.
      pre_beat   <= beat_cnt;
      hit_pulse  <= 1'b0;
      bad_press  <= 1'b0;
      miss_pulse <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pre_beat    <= beat_cnt;
      h_q         <= h_d;
      block_valid <= valid_d;
      hit_pulse   <= key_press && hit_found;
      bad_press   <= key_press && !hit_found;
      miss_pulse  <= |miss_vec;
      overflow    <= spawn_req && !spawn_found;
      if (key_press && hit_found && (hit_cnt != CNT_MAX)) hit_cnt <= hit_cnt + CNT_W'(1);
      miss_cnt    <= (miss_sum > SW'(CNT_MAX)) ? CNT_MAX : miss_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_lane_block_pool.sv
// Bench for lane_block_pool: directed scenarios plus random traffic against a behavioural model.
// Instance A uses default geometry; instance B has 2 slots, spawns at 700 and has a window up to 719.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_lane_block_pool;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_restart = 1'b0, a_stop = 1'b0, a_spawn = 1'b0, a_key = 1'b0;
  logic [6:0] a_beat = '0;
  logic [39:0] a_h;
  logic [3:0]  a_v;
  logic        a_hit, a_bad, a_miss, a_ovf;
  logic [7:0]  a_hitc, a_missc;

  logic       b_restart = 1'b0, b_stop = 1'b0, b_spawn = 1'b0, b_key = 1'b0;
  logic [6:0] b_beat = '0;
  logic [19:0] b_h;
  logic [1:0]  b_v;
  logic        b_hit, b_bad, b_miss, b_ovf;
  logic [7:0]  b_hitc, b_missc;

  lane_block_pool dut_a (
    .clk(clk), .rst(rst), .restart(a_restart), .stop_or_endgame(a_stop),
    .beat_cnt(a_beat), .spawn_en(a_spawn), .key_press(a_key),
    .block_h(a_h), .block_valid(a_v), .hit_pulse(a_hit), .bad_press(a_bad),
    .miss_pulse(a_miss), .overflow(a_ovf), .hit_cnt(a_hitc), .miss_cnt(a_missc)
  );

  lane_block_pool #(.SLOTS(2), .SPAWN_H(700), .HIT_HI(719)) dut_b (
    .clk(clk), .rst(rst), .restart(b_restart), .stop_or_endgame(b_stop),
    .beat_cnt(b_beat), .spawn_en(b_spawn), .key_press(b_key),
    .block_h(b_h), .block_valid(b_v), .hit_pulse(b_hit), .bad_press(b_bad),
    .miss_pulse(b_miss), .overflow(b_ovf), .hit_cnt(b_hitc), .miss_cnt(b_missc)
  );

  logic [63:0] a_obs;
  logic [41:0] b_obs;
  assign a_obs = {a_h, a_v, a_hit, a_bad, a_miss, a_ovf, a_hitc, a_missc};
  assign b_obs = {b_h, b_v, b_hit, b_bad, b_miss, b_ovf, b_hitc, b_missc};

  int checks = 0;
  int errors = 0;

  // Behavioural model: per-instance block list as plain integers.
  localparam int BOTTOM = 720;
  localparam int LO     = 600;
  int p_slots [2] = '{4, 2};
  int p_spawn [2] = '{120, 700};
  int p_hi    [2] = '{680, 719};
  int m_h [2][4];
  bit m_v [2][4];
  int m_pre [2];
  int m_hitc [2];
  int m_missc [2];
  bit m_hp [2], m_bp [2], m_mp [2], m_op [2];

  task automatic model_reset(input int k);
    for (int i = 0; i < 4; i++) begin
      m_h[k][i] = BOTTOM;
      m_v[k][i] = 1'b0;
    end
    m_pre[k] = 0; m_hitc[k] = 0; m_missc[k] = 0;
    m_hp[k] = 0; m_bp[k] = 0; m_mp[k] = 0; m_op[k] = 0;
  endtask

  task automatic model_step(input int k, input bit rs, input bit st, input int beat,
                            input bit sp, input bit key);
    int  best, fr, misses;
    bit  add;
    if (rs) begin
      model_reset(k);
      return;
    end
    m_hp[k] = 0; m_bp[k] = 0; m_mp[k] = 0; m_op[k] = 0;
    add = beat > m_pre[k];
    m_pre[k] = beat;
    if (st) return;
    best = -1;
    fr   = -1;
    for (int i = 0; i < p_slots[k]; i++) begin
      if (m_v[k][i] && m_h[k][i] >= LO && m_h[k][i] <= p_hi[k] &&
          (best < 0 || m_h[k][i] > m_h[k][best])) best = i;
      if (!m_v[k][i] && fr < 0) fr = i;
    end
    if (key && best >= 0) begin
      m_hp[k] = 1;
      if (m_hitc[k] < 255) m_hitc[k]++;
    end else if (key) begin
      m_bp[k] = 1;
    end
    misses = 0;
    for (int i = 0; i < p_slots[k]; i++) begin
      if (m_v[k][i]) begin
        if (key && i == best) begin
          m_v[k][i] = 0; m_h[k][i] = BOTTOM;
        end else if (m_h[k][i] + 1 >= BOTTOM) begin
          m_v[k][i] = 0; m_h[k][i] = BOTTOM; misses++;
        end else begin
          m_h[k][i] = m_h[k][i] + 1;
        end
      end
    end
    if (misses > 0) m_mp[k] = 1;
    m_missc[k] = (m_missc[k] + misses > 255) ? 255 : m_missc[k] + misses;
    if (add && sp) begin
      if (fr >= 0) begin
        m_v[k][fr] = 1; m_h[k][fr] = p_spawn[k];
      end else begin
        m_op[k] = 1;
      end
    end
  endtask

  function automatic logic [63:0] exp_a();
    logic [39:0] h;
    logic [3:0]  v;
    for (int i = 0; i < 4; i++) begin
      h[i*10 +: 10] = 10'(m_h[0][i]);
      v[i] = m_v[0][i];
    end
    return {h, v, m_hp[0], m_bp[0], m_mp[0], m_op[0], 8'(m_hitc[0]), 8'(m_missc[0])};
  endfunction

  function automatic logic [41:0] exp_b();
    logic [19:0] h;
    logic [1:0]  v;
    for (int i = 0; i < 2; i++) begin
      h[i*10 +: 10] = 10'(m_h[1][i]);
      v[i] = m_v[1][i];
    end
    return {h, v, m_hp[1], m_bp[1], m_mp[1], m_op[1], 8'(m_hitc[1]), 8'(m_missc[1])};
  endfunction

  // Advance both models with the inputs currently applied, then clock the DUTs.
  task automatic cycle();
    model_step(0, a_restart, a_stop, int'(a_beat), a_spawn, a_key);
    model_step(1, b_restart, b_stop, int'(b_beat), b_spawn, b_key);
    @(posedge clk);
    #1;
  endtask

  task automatic restart_a();
    a_restart = 1; a_beat = 0; a_spawn = 0; a_key = 0; a_stop = 0;
    cycle();
    a_restart = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_obs !== exp_a()) begin
      errors++; $display("FAIL reset_a got=%h exp=%h", a_obs, exp_a());
    end
    checks++;
    if (a_h !== {4{10'd720}} || a_v !== 4'b0 || a_hitc !== 8'd0 || a_missc !== 8'd0) begin
      errors++; $display("FAIL reset_const got h=%h v=%b hc=%0d mc=%0d", a_h, a_v, a_hitc, a_missc);
    end
    checks++;
    if (b_obs !== exp_b()) begin
      errors++; $display("FAIL reset_b got=%h exp=%h", b_obs, exp_b());
    end
    rst = 0;
  endtask

  task automatic test_spawn_travel();
    a_beat = 7; a_spawn = 1;
    cycle();
    a_spawn = 0;
    checks++;
    if (a_v !== 4'b0001 || a_h[9:0] !== 10'd120) begin
      errors++; $display("FAIL spawn got v=%b h0=%0d exp v=0001 h0=120", a_v, a_h[9:0]);
    end
    for (int n = 1; n < 600; n++) begin
      cycle();
      checks++;
      if (a_obs !== exp_a()) begin
        errors++; $display("FAIL travel n=%0d got=%h exp=%h", n, a_obs, exp_a());
      end
    end
    cycle();
    checks++;
    if (a_miss !== 1'b1 || a_missc !== 8'd1 || a_v !== 4'b0) begin
      errors++; $display("FAIL floor_miss got p=%b mc=%0d v=%b exp 1 1 0000", a_miss, a_missc, a_v);
    end
  endtask

  task automatic test_overflow();
    a_beat = 0; a_spawn = 1;
    cycle();
    checks++;
    if (a_v !== 4'b0) begin
      errors++; $display("FAIL wrap_no_spawn got v=%b exp 0000", a_v);
    end
    for (int b = 1; b <= 5; b++) begin
      a_beat = 7'(b);
      cycle();
      checks++;
      if (a_obs !== exp_a()) begin
        errors++; $display("FAIL fill b=%0d got=%h exp=%h", b, a_obs, exp_a());
      end
    end
    a_spawn = 0;
    checks++;
    if (a_ovf !== 1'b1 || a_v !== 4'hF || a_h !== {10'd121, 10'd122, 10'd123, 10'd124}) begin
      errors++; $display("FAIL overflow got o=%b v=%b h=%h", a_ovf, a_v, a_h);
    end
    restart_a();
  endtask

  task automatic test_hit_order();
    a_beat = 1; a_spawn = 1;
    cycle();
    a_spawn = 0;
    repeat (39) cycle();
    a_beat = 2; a_spawn = 1;
    cycle();
    a_spawn = 0;
    for (int n = 0; n < 490; n++) begin
      cycle();
      checks++;
      if (a_obs !== exp_a()) begin
        errors++; $display("FAIL approach n=%0d got=%h exp=%h", n, a_obs, exp_a());
      end
    end
    checks++;
    if (a_h[9:0] !== 10'd650 || a_h[19:10] !== 10'd610) begin
      errors++; $display("FAIL setup got h0=%0d h1=%0d exp 650 610", a_h[9:0], a_h[19:10]);
    end
    a_key = 1;
    cycle();
    checks++;
    if (a_hit !== 1'b1 || a_v !== 4'b0010 || a_h[19:10] !== 10'd611 || a_hitc !== 8'd1) begin
      errors++; $display("FAIL hit_high got p=%b v=%b h1=%0d hc=%0d", a_hit, a_v, a_h[19:10], a_hitc);
    end
    cycle();
    a_key = 0;
    checks++;
    if (a_hit !== 1'b1 || a_v !== 4'b0 || a_hitc !== 8'd2) begin
      errors++; $display("FAIL hit_second got p=%b v=%b hc=%0d", a_hit, a_v, a_hitc);
    end
    cycle();
    checks++;
    if (a_obs !== exp_a()) begin
      errors++; $display("FAIL hit_after got=%h exp=%h", a_obs, exp_a());
    end
  endtask

  task automatic test_restart();
    a_spawn = 1;
    for (int b = 3; b <= 5; b++) begin
      a_beat = 7'(b);
      cycle();
    end
    checks++;
    if (a_v !== 4'b0111) begin
      errors++; $display("FAIL three_live got v=%b exp 0111", a_v);
    end
    a_restart = 1; a_key = 1; a_beat = 6;
    cycle();
    a_restart = 0; a_key = 0; a_spawn = 0;
    checks++;
    if (a_v !== 4'b0 || a_h !== {4{10'd720}} || a_hitc !== 8'd0 || a_missc !== 8'd0 ||
        {a_hit, a_bad, a_miss, a_ovf} !== 4'b0) begin
      errors++; $display("FAIL restart got v=%b hc=%0d mc=%0d p=%b", a_v, a_hitc, a_missc,
                         {a_hit, a_bad, a_miss, a_ovf});
    end
  endtask

  task automatic test_bad_press();
    restart_a();
    a_beat = 1; a_spawn = 1;
    cycle();
    a_spawn = 0;
    repeat (5) cycle();
    a_key = 1;
    cycle();
    a_key = 0;
    checks++;
    if (a_bad !== 1'b1 || a_hit !== 1'b0 || a_v !== 4'b0001 || a_h[9:0] !== 10'd126) begin
      errors++; $display("FAIL bad_low got b=%b h=%b v=%b h0=%0d", a_bad, a_hit, a_v, a_h[9:0]);
    end
    repeat (473) cycle();
    a_key = 1;
    cycle();
    checks++;
    if (a_bad !== 1'b1 || a_v !== 4'b0001 || a_h[9:0] !== 10'd600) begin
      errors++; $display("FAIL edge_599 got b=%b v=%b h0=%0d", a_bad, a_v, a_h[9:0]);
    end
    cycle();
    a_key = 0;
    checks++;
    if (a_hit !== 1'b1 || a_v !== 4'b0 || a_hitc !== 8'd1) begin
      errors++; $display("FAIL edge_600 got p=%b v=%b hc=%0d", a_hit, a_v, a_hitc);
    end
    a_beat = 2; a_spawn = 1;
    cycle();
    a_spawn = 0;
    repeat (561) cycle();
    a_key = 1;
    cycle();
    a_key = 0;
    checks++;
    if (a_bad !== 1'b1 || a_v !== 4'b0001 || a_h[9:0] !== 10'd682) begin
      errors++; $display("FAIL edge_681 got b=%b v=%b h0=%0d", a_bad, a_v, a_h[9:0]);
    end
  endtask

  task automatic test_floor_hit();
    b_restart = 1; b_beat = 0;
    cycle();
    b_restart = 0;
    b_beat = 1; b_spawn = 1;
    cycle();
    b_spawn = 0;
    for (int n = 0; n < 19; n++) begin
      cycle();
      checks++;
      if (b_obs !== exp_b()) begin
        errors++; $display("FAIL b_fall n=%0d got=%h exp=%h", n, b_obs, exp_b());
      end
    end
    b_key = 1;
    cycle();
    b_key = 0;
    checks++;
    if (b_hit !== 1'b1 || b_miss !== 1'b0 || b_missc !== 8'd0 || b_hitc !== 8'd1 || b_v !== 2'b0) begin
      errors++; $display("FAIL floor_hit got h=%b m=%b mc=%0d hc=%0d v=%b", b_hit, b_miss, b_missc,
                         b_hitc, b_v);
    end
  endtask

  task automatic test_stop();
    restart_a();
    a_beat = 1; a_spawn = 1;
    cycle();
    a_spawn = 0;
    repeat (10) cycle();
    a_stop = 1;
    for (int n = 0; n < 50; n++) begin
      if (n == 20) begin
        a_beat = 2; a_spawn = 1;
      end
      a_key = n[0];
      cycle();
      checks++;
      if (a_obs !== exp_a() || a_h[9:0] !== 10'd130 || a_v !== 4'b0001 ||
          {a_hit, a_bad, a_miss, a_ovf} !== 4'b0) begin
        errors++; $display("FAIL frozen n=%0d got=%h exp=%h", n, a_obs, exp_a());
      end
    end
    a_stop = 0; a_key = 0;
    cycle();
    a_spawn = 0;
    checks++;
    if (a_h[9:0] !== 10'd131 || a_v !== 4'b0001) begin
      errors++; $display("FAIL resume got h0=%0d v=%b exp 131 0001", a_h[9:0], a_v);
    end
  endtask

  task automatic test_saturate();
    int n;
    int seen;
    b_restart = 1; b_beat = 0;
    cycle();
    b_restart = 0;
    b_spawn = 1;
    n = 0;
    while (m_missc[1] < 255 && n < 5000) begin
      b_beat = b_beat + 7'd1;
      cycle();
      n++;
      checks++;
      if (b_obs !== exp_b()) begin
        errors++; $display("FAIL sat_run n=%0d got=%h exp=%h", n, b_obs, exp_b());
      end
    end
    checks++;
    if (m_missc[1] < 255) begin
      errors++; $display("FAIL sat_timeout got misses=%0d exp 255 within 5000 cycles", m_missc[1]);
    end
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      b_beat = b_beat + 7'd1;
      cycle();
      if (b_miss === 1'b1) seen++;
    end
    b_spawn = 0;
    checks++;
    if (b_missc !== 8'd255 || seen == 0) begin
      errors++; $display("FAIL saturate got mc=%0d pulses=%0d exp 255 and >0", b_missc, seen);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      a_restart = ($urandom_range(0, 499) == 0);
      b_restart = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) a_stop = ~a_stop;
      if ($urandom_range(0, 39) == 0) b_stop = ~b_stop;
      if ($urandom_range(0, 3) == 0) a_beat = ($urandom_range(0, 15) == 0) ? 7'd0 : a_beat + 7'd1;
      if ($urandom_range(0, 3) == 0) b_beat = ($urandom_range(0, 15) == 0) ? 7'd0 : b_beat + 7'd1;
      a_spawn = 1'($urandom_range(0, 1));
      b_spawn = 1'($urandom_range(0, 1));
      a_key = ($urandom_range(0, 3) == 0);
      b_key = ($urandom_range(0, 7) == 0);
      cycle();
      checks++;
      if (a_obs !== exp_a()) begin
        errors++; $display("FAIL rand_a n=%0d got=%h exp=%h", n, a_obs, exp_a());
      end
      checks++;
      if (b_obs !== exp_b()) begin
        errors++; $display("FAIL rand_b n=%0d got=%h exp=%h", n, b_obs, exp_b());
      end
    end
  endtask

  initial begin
    test_reset();
    test_spawn_travel();
    test_overflow();
    test_hit_order();
    test_restart();
    test_bad_press();
    test_floor_hit();
    test_stop();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
